// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receive engine, mid-bit sampling, one-cycle strobes.
// Optional 2-of-3 majority sampling when UART_RX_MAJORITY_EN is defined.
module uart_rx #(
  parameter int div_ratio = 868
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_line,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW  = $clog2(div_ratio + 1);
  localparam int MID = div_ratio / 2;

`ifdef UART_RX_MAJORITY_EN
  localparam int START_AT = MID;
`else
  localparam int START_AT = MID - 1;
`endif

  localparam logic [CW-1:0] C_START = CW'(START_AT);
  localparam logic [CW-1:0] C_BIT   = CW'(div_ratio - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t          r_state;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_bitcnt;
  logic [7:0]      r_shreg;
  logic            r_sync1;
  logic            r_sync2;
  logic            w_rx_s;
  logic            w_bit;

  assign w_rx_s = r_sync2;

`ifdef UART_RX_MAJORITY_EN
  logic r_h1;
  logic r_h2;

  // Two-deep history of rx_s for the S-1/S/S+1 vote
  always_ff @(posedge clk) begin
    if (rst) begin
      r_h1 <= 1'b1;
      r_h2 <= 1'b1;
    end else begin
      r_h1 <= w_rx_s;
      r_h2 <= r_h1;
    end
  end

  assign w_bit = (r_h2 & r_h1) | (r_h2 & w_rx_s) | (r_h1 & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  // Two-flop synchronizer, idles high
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx_line;
      r_sync2 <= r_sync1;
    end
  end

  // Frame FSM with registered strobes and busy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_bitcnt  <= '0;
      r_shreg   <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      busy      <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      r_cnt     <= CW'(r_cnt + 1'b1);
      unique case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= S_START;
            busy    <= 1'b1;
          end
        end
        S_START: begin
          if (r_cnt == C_START) begin
            r_cnt <= '0;
            if (!w_bit) begin
              r_state  <= S_DATA;
              r_bitcnt <= '0;
            end else begin
              r_state <= S_IDLE;
              busy    <= 1'b0;
            end
          end
        end
        S_DATA: begin
          if (r_cnt == C_BIT) begin
            r_cnt             <= '0;
            r_shreg[r_bitcnt] <= w_bit;
            r_bitcnt          <= 3'(r_bitcnt + 1'b1);
            if (r_bitcnt == 3'd7) begin
              r_state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          if (r_cnt == C_BIT) begin
            r_cnt <= '0;
            if (w_bit) begin
              rx_data  <= r_shreg;
              rx_valid <= 1'b1;
              r_state  <= S_IDLE;
              busy     <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              r_state   <= S_BREAK;
            end
          end
        end
        S_BREAK: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= S_IDLE;
            busy    <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with a waveform-level
// reference that samples the ideal line at the nominal bit instants.
module tb_uart_rx;

  localparam int DIV = 16;
  localparam int MID = DIV / 2;
`ifdef UART_RX_MAJORITY_EN
  localparam int LAT = MID + 4;
`else
  localparam int LAT = MID + 3;
`endif

  typedef struct {
    bit         ferr;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       rx_line;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  exp_t       q[$];
  int         checks;
  int         failures;
  int         cyc;
  logic       rst_q;
  logic [7:0] prev_data;
  logic [7:0] last_good;

  uart_rx #(.div_ratio(DIV)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_line   (rx_line),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    cyc   = 0;
    rst_q = 1'b1;
  end

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cyc=%0d",
               nm, act, req, cyc);
    end
  endtask

  // Ideal line level t cycles after the start edge
  function automatic bit line_at(input int t, input logic [7:0] d,
                                 input int per, input bit sb,
                                 input int tl, input int gl);
    bit v;
    logic [2:0] idx;
    if (t < per) begin
      v = 1'b0;
    end else if (t < 9 * per) begin
      idx = 3'(t / per - 1);
      v = d[idx];
    end else if (t < 10 * per) begin
      v = sb;
    end else if (t < 10 * per + tl) begin
      v = 1'b0;
    end else begin
      v = 1'b1;
    end
    if (t == gl) v = ~v;
    return v;
  endfunction

  function automatic bit samp(input int t, input logic [7:0] d,
                              input int per, input bit sb,
                              input int tl, input int gl);
`ifdef UART_RX_MAJORITY_EN
    int n;
    n = int'(line_at(t - 1, d, per, sb, tl, gl)) +
        int'(line_at(t, d, per, sb, tl, gl)) +
        int'(line_at(t + 1, d, per, sb, tl, gl));
    return n >= 2;
`else
    return line_at(t, d, per, sb, tl, gl);
`endif
  endfunction

  // Drive one frame; push the predicted receiver response first
  task automatic send(input logic [7:0] d, input int per, input bit sb,
                      input int tl, input int gl, input int gap,
                      input int probe);
    exp_t e;
    bit s[10];
    int total;
    for (int k = 0; k < 10; k++)
      s[k] = samp(MID + k * DIV, d, per, sb, tl, gl);
    if (!s[0]) begin
      e.ferr = ~s[9];
      e.cyc  = cyc + LAT + 9 * DIV;
      if (s[9]) begin
        for (int k = 0; k < 8; k++) e.data[k] = s[k + 1];
        last_good = e.data;
      end else begin
        e.data = last_good;
      end
      q.push_back(e);
    end
    total = 10 * per + tl + gap;
    for (int t = 0; t < total; t++) begin
      rx_line = line_at(t, d, per, sb, tl, gl);
      if (t == probe) chk("busy_probe", int'(busy), 1);
      @(negedge clk);
    end
    chk("busy_idle", int'(busy), 0);
  endtask

  // Scoreboard monitor: pop and compare on every strobe
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst_q) begin
      if (rx_valid || frame_err) begin
        chk("strobe_excl", int'(rx_valid && frame_err), 0);
        if (q.size() == 0) begin
          chk("unexpected_strobe", 1, 0);
        end else begin
          e = q.pop_front();
          chk("strobe_kind_ferr", int'(frame_err), int'(e.ferr));
          chk("rx_data", int'(rx_data), int'(e.data));
          chk("strobe_cycle", cyc, e.cyc);
          if (rx_valid) chk("busy_at_valid", int'(busy), 0);
        end
      end
      if (!rx_valid && rx_data !== prev_data)
        chk("rx_data_hold", int'(rx_data), int'(prev_data));
    end
    prev_data = rx_data;
  end

  initial begin
    int per;
    bit sb;
    checks    = 0;
    failures  = 0;
    last_good = 8'h00;
    prev_data = 8'h00;
    rst       = 1'b1;
    rx_line   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_valid", int'(rx_valid), 0);
    chk("rst_ferr", int'(frame_err), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_data", int'(rx_data), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    send(8'hA5, DIV, 1'b1, 0, -1, 20, -1);
    send(8'h00, DIV, 1'b1, 0, -1, 0, -1);
    send(8'hFF, DIV, 1'b1, 0, -1, 20, -1);

    rx_line = 1'b0;
    repeat (4) @(negedge clk);
    rx_line = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_busy", int'(busy), 0);
    send(8'h3C, DIV, 1'b1, 0, -1, 20, -1);

    send(8'h55, DIV, 1'b0, 40, -1, 20, 10 * DIV + 30);

    for (int t = 0; t < 4 * DIV; t++) begin
      rx_line = line_at(t, 8'hC3, DIV, 1'b1, 0, -1);
      @(negedge clk);
    end
    chk("mid_data_busy", int'(busy), 1);
    rst     = 1'b1;
    rx_line = 1'b1;
    @(negedge clk);
    chk("mrst_valid", int'(rx_valid), 0);
    chk("mrst_ferr", int'(frame_err), 0);
    chk("mrst_busy", int'(busy), 0);
    chk("mrst_data", int'(rx_data), 0);
    rst       = 1'b0;
    last_good = 8'h00;
    repeat (20) @(negedge clk);
    send(8'h81, DIV, 1'b1, 0, -1, 20, -1);

    send(8'h96, 15, 1'b1, 0, -1, 20, -1);
    send(8'h96, 17, 1'b1, 0, -1, 20, -1);
    send(8'h96, DIV, 1'b1, 0, MID + 4 * DIV, 20, -1);

    for (int i = 0; i < 20; i++) begin
      per = 15 + $urandom_range(0, 2);
      sb  = (per == DIV) ? ($urandom_range(0, 7) != 0) : 1'b1;
      send(8'($urandom), per, sb, 0, -1, $urandom_range(8, 30), -1);
    end

    for (int i = 0; i < 500 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
